// File: rtl/logo_motion_if.sv
// Scan-position inputs and logo-position outputs shared between the
// bouncing-logo position generator and the logo graphics stage.
interface logo_motion_if;
   logic [9:0] x_px;
   logic [9:0] y_px;
   logic       pause;
   logic [9:0] x_logo;
   logic [9:0] y_logo;
   logic       dir_x;
   logic       dir_y;
   logic       bounce;
   logic       corner_hit;

   modport master (
      output x_px, y_px, pause,
      input  x_logo, y_logo, dir_x, dir_y, bounce, corner_hit
   );

   modport slave (
      input  x_px, y_px, pause,
      output x_logo, y_logo, dir_x, dir_y, bounce, corner_hit
   );
endinterface

// File: rtl/logo_motion.sv
// Bouncing-logo position generator: one position step per blanking interval.
// Optional corner_hit pulse is built only when LOGO_MOTION_CORNER_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WAIT    | visible area, waiting for the start of vertical blanking
// STEP_X  | advance x_logo / reverse dir_x at the screen edge
// STEP_Y  | advance y_logo / reverse dir_y at the screen edge
// HOLD    | update done (or skipped) for this blanking, wait for video
module logo_motion #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int WIDTH_LOGO  = 80,
   parameter int HEIGHT_LOGO = 96,
   parameter int X_INIT      = 0,
   parameter int Y_INIT      = 0,
   parameter int STEP        = 1,
   parameter int FRAME_DIV   = 1
) (
   input logic          clk,
   input logic          clr,
   logo_motion_if.slave lm
);

   localparam logic [1:0] S_WAIT   = 2'd0;
   localparam logic [1:0] S_STEP_X = 2'd1;
   localparam logic [1:0] S_STEP_Y = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [10:0] X_MAX11  = 11'(H_ACTIVE - WIDTH_LOGO);
   localparam logic [10:0] Y_MAX11  = 11'(V_ACTIVE - HEIGHT_LOGO);
   localparam logic [9:0]  X_MAX10  = 10'(H_ACTIVE - WIDTH_LOGO);
   localparam logic [9:0]  Y_MAX10  = 10'(V_ACTIVE - HEIGHT_LOGO);
   localparam logic [10:0] STEP11   = 11'(STEP);
   localparam logic [9:0]  STEP10   = 10'(STEP);
   localparam logic [9:0]  V_ACT10  = 10'(V_ACTIVE);
   localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

   logic [1:0]  state;
   logic        blank_q;
   logic        blank_d;
   logic [7:0]  frame_cnt;
   logic [9:0]  x_q;
   logic [9:0]  y_q;
   logic        dx_q;
   logic        dy_q;
   logic        flip_x_q;
   logic        flip_y_q;
   logic        bounce_q;

   logic        blank_rise;
   logic [10:0] x_sum;
   logic [10:0] y_sum;
   logic        x_hit;
   logic        y_hit;
   logic [9:0]  x_next;
   logic [9:0]  y_next;
   logic        unused_x_px;

   // blank_d resets high with blank_q, so leaving reset inside blanking
   // does not look like a new blanking edge.
   assign blank_rise = blank_q & ~blank_d;

   assign x_sum = {1'b0, x_q} + STEP11;
   assign y_sum = {1'b0, y_q} + STEP11;

   always_comb begin
      x_hit  = 1'b0;
      x_next = x_q;
      if (dx_q) begin
         x_hit  = ({1'b0, x_q} <= STEP11);
         x_next = x_hit ? 10'd0 : (x_q - STEP10);
      end else begin
         x_hit  = (x_sum >= X_MAX11);
         x_next = x_hit ? X_MAX10 : x_sum[9:0];
      end
   end

   always_comb begin
      y_hit  = 1'b0;
      y_next = y_q;
      if (dy_q) begin
         y_hit  = ({1'b0, y_q} <= STEP11);
         y_next = y_hit ? 10'd0 : (y_q - STEP10);
      end else begin
         y_hit  = (y_sum >= Y_MAX11);
         y_next = y_hit ? Y_MAX10 : y_sum[9:0];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= S_WAIT;
         blank_q   <= 1'b1;
         blank_d   <= 1'b1;
         frame_cnt <= 8'd0;
         x_q       <= 10'(X_INIT);
         y_q       <= 10'(Y_INIT);
         dx_q      <= 1'b0;
         dy_q      <= 1'b0;
         flip_x_q  <= 1'b0;
         flip_y_q  <= 1'b0;
         bounce_q  <= 1'b0;
      end else begin
         blank_q  <= (lm.y_px >= V_ACT10);
         blank_d  <= blank_q;
         flip_x_q <= 1'b0;
         flip_y_q <= 1'b0;
         bounce_q <= flip_x_q | flip_y_q;
         case (state)
            S_WAIT: begin
               if (blank_rise) begin
                  if (lm.pause) begin
                     state <= S_HOLD;
                  end else if (frame_cnt == DIV_LAST) begin
                     frame_cnt <= 8'd0;
                     state     <= S_STEP_X;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                     state     <= S_HOLD;
                  end
               end
            end
            S_STEP_X: begin
               x_q      <= x_next;
               flip_x_q <= x_hit;
               if (x_hit) dx_q <= ~dx_q;
               state    <= S_STEP_Y;
            end
            S_STEP_Y: begin
               y_q      <= y_next;
               flip_y_q <= y_hit;
               if (y_hit) dy_q <= ~dy_q;
               state    <= S_HOLD;
            end
            S_HOLD: begin
               if (!blank_q) state <= S_WAIT;
            end
            default: state <= S_WAIT;
         endcase
      end
   end

`ifdef LOGO_MOTION_CORNER_EN
   logic x_flip_mem;
   logic corner_q;

   // x_flip_mem lines the X flip up with the Y flip one cycle later
   always_ff @(posedge clk) begin
      if (clr) begin
         x_flip_mem <= 1'b0;
         corner_q   <= 1'b0;
      end else begin
         x_flip_mem <= flip_x_q;
         corner_q   <= flip_y_q & x_flip_mem;
      end
   end

   assign lm.corner_hit = corner_q;
`else
   assign lm.corner_hit = 1'b0;
`endif

   // x_px only mirrors the graphics-stage interface
   assign unused_x_px = ^lm.x_px;

   assign lm.x_logo = x_q;
   assign lm.y_logo = y_q;
   assign lm.dir_x  = dx_q;
   assign lm.dir_y  = dy_q;
   assign lm.bounce = bounce_q;

endmodule

// File: tb/tb_logo_motion.sv
// Randomized frame-level bench for logo_motion: three parameterizations share
// one scan stream; a frame model feeds per-instance queues checked by a monitor.
module tb_logo_motion;

`ifdef LOGO_MOTION_CORNER_EN
   localparam bit CORNER = 1'b1;
`else
   localparam bit CORNER = 1'b0;
`endif

   localparam int XMAX = 560;
   localparam int YMAX = 384;

   typedef struct {
      int x;
      int y;
      int dx;
      int dy;
      int x_off;
      int y_off;
      int bmask;
      int cmask;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr;
   logic [9:0] x_px;
   logic [9:0] y_px;
   logic       pause;

   always #5 clk = ~clk;

   logo_motion_if if0();
   logo_motion_if if1();
   logo_motion_if if2();

   assign if0.x_px = x_px;  assign if0.y_px = y_px;  assign if0.pause = pause;
   assign if1.x_px = x_px;  assign if1.y_px = y_px;  assign if1.pause = pause;
   assign if2.x_px = x_px;  assign if2.y_px = y_px;  assign if2.pause = pause;

   logo_motion #(.X_INIT(0), .Y_INIT(0), .STEP(1), .FRAME_DIV(1))
      dut0 (.clk(clk), .clr(clr), .lm(if0));
   logo_motion #(.X_INIT(460), .Y_INIT(84), .STEP(100), .FRAME_DIV(1))
      dut1 (.clk(clk), .clr(clr), .lm(if1));
   logo_motion #(.X_INIT(559), .Y_INIT(383), .STEP(1), .FRAME_DIV(4))
      dut2 (.clk(clk), .clr(clr), .lm(if2));

   int PXI [3] = '{0, 460, 559};
   int PYI [3] = '{0, 84, 383};
   int PST [3] = '{1, 100, 1};
   int PDIV[3] = '{1, 1, 4};

   logic [9:0] ox [3];
   logic [9:0] oy [3];
   logic       odx[3];
   logic       ody[3];
   logic       ob [3];
   logic       oc [3];

   assign ox[0] = if0.x_logo; assign oy[0] = if0.y_logo; assign odx[0] = if0.dir_x;
   assign ody[0] = if0.dir_y; assign ob[0] = if0.bounce; assign oc[0] = if0.corner_hit;
   assign ox[1] = if1.x_logo; assign oy[1] = if1.y_logo; assign odx[1] = if1.dir_x;
   assign ody[1] = if1.dir_y; assign ob[1] = if1.bounce; assign oc[1] = if1.corner_hit;
   assign ox[2] = if2.x_logo; assign oy[2] = if2.y_logo; assign odx[2] = if2.dir_x;
   assign ody[2] = if2.dir_y; assign ob[2] = if2.bounce; assign oc[2] = if2.corner_hit;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[3][$];

   int mx[3], my[3], mcnt[3];
   bit mdx[3], mdy[3];

   bit mon_en = 1'b0;

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, req);
      end
   endtask

   // One axis move in plain integer arithmetic: overshoot or landing on a wall clamps and reverses.
   task automatic axis(inout int pos, inout bit dir, input int lim, input int st,
                       output bit flipped);
      int np;
      np = dir ? pos - st : pos + st;
      flipped = 1'b0;
      if (np >= lim) begin
         np = lim;
         flipped = 1'b1;
      end else if (np <= 0) begin
         np = 0;
         flipped = 1'b1;
      end
      if (flipped) dir = ~dir;
      pos = np;
   endtask

   task automatic model_frame(input int d, input bit pz, input bit cl);
      exp_t e;
      int   old_x, old_y;
      bit   fx, fy;
      old_x = mx[d];
      old_y = my[d];
      fx = 1'b0;
      fy = 1'b0;
      e.bmask = 0;
      e.cmask = 0;
      if (cl) begin
         mx[d] = PXI[d];  my[d] = PYI[d];
         mdx[d] = 1'b0;   mdy[d] = 1'b0;
         mcnt[d] = 0;
         e.x_off = (mx[d] != old_x) ? 2 : -1;
         e.y_off = (my[d] != old_y) ? 2 : -1;
      end else begin
         if (!pz) begin
            mcnt[d]++;
            if (mcnt[d] == PDIV[d]) begin
               mcnt[d] = 0;
               axis(mx[d], mdx[d], XMAX, PST[d], fx);
               axis(my[d], mdy[d], YMAX, PST[d], fy);
            end
         end
         e.x_off = (mx[d] != old_x) ? 2 : -1;
         e.y_off = (my[d] != old_y) ? 3 : -1;
         e.bmask = (fx ? 8 : 0) | (fy ? 16 : 0);
         e.cmask = (CORNER && fx && fy) ? 16 : 0;
      end
      e.x = mx[d];
      e.y = my[d];
      e.dx = int'(mdx[d]);
      e.dy = int'(mdy[d]);
      exp_q[d].push_back(e);
   endtask

   // Monitor: gathers per-blanking observations and pops one expectation per blanking.
   int cyc = 0;
   bit in_blank = 1'b0;
   int kb = 0;
   int xprev[3], yprev[3], xoff[3], yoff[3], bm[3], cm[3], stray[3];

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (mon_en) begin
            automatic bit bs = (y_px >= 10'd480);
            automatic int off;
            if (bs && !in_blank) begin
               in_blank = 1'b1;
               kb = cyc;
               for (int d = 0; d < 3; d++) begin
                  xoff[d] = -1; yoff[d] = -1; bm[d] = 0; cm[d] = 0;
               end
            end
            off = cyc - kb;
            for (int d = 0; d < 3; d++) begin
               if (bs) begin
                  if (int'(ox[d]) != xprev[d] && xoff[d] < 0) xoff[d] = off;
                  if (int'(oy[d]) != yprev[d] && yoff[d] < 0) yoff[d] = off;
                  if (ob[d] === 1'b1 && off < 31) bm[d] |= (1 << off);
                  if (oc[d] === 1'b1 && off < 31) cm[d] |= (1 << off);
               end else begin
                  if (int'(ox[d]) != xprev[d] || int'(oy[d]) != yprev[d] ||
                      ob[d] !== 1'b0 || oc[d] !== 1'b0) stray[d]++;
               end
               xprev[d] = int'(ox[d]);
               yprev[d] = int'(oy[d]);
            end
            if (!bs && in_blank) begin
               in_blank = 1'b0;
               for (int d = 0; d < 3; d++) begin
                  if (exp_q[d].size() == 0) begin
                     check("expect_queue_empty", d, 1, 0);
                  end else begin
                     automatic exp_t e = exp_q[d].pop_front();
                     check("x_logo", d, ox[d], e.x);
                     check("y_logo", d, oy[d], e.y);
                     check("dir_x", d, odx[d], e.dx);
                     check("dir_y", d, ody[d], e.dy);
                     check("x_update_cycle", d, xoff[d], e.x_off);
                     check("y_update_cycle", d, yoff[d], e.y_off);
                     check("bounce_pulses", d, bm[d], e.bmask);
                     check("corner_pulses", d, cm[d], e.cmask);
                     check("stable_in_active", d, stray[d], 0);
                  end
                  stray[d] = 0;
               end
            end
         end
      end
   end

   task automatic run_frame(input bit pz, input bit cl);
      int n;
      for (int d = 0; d < 3; d++) model_frame(d, pz, cl);
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         y_px  = 10'($urandom_range(0, 479));
         x_px  = 10'($urandom_range(0, 1023));
         pause = 1'($urandom_range(0, 1));
         clr   = 1'b0;
      end
      n = $urandom_range(5, 9);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         y_px  = 10'($urandom_range(480, 1023));
         x_px  = 10'($urandom_range(0, 1023));
         pause = pz;
         clr   = cl && (i == 2 || i == 3);
      end
   endtask

   initial begin
      clr   = 1'b1;
      y_px  = 10'd600;
      x_px  = 10'd0;
      pause = 1'b0;
      for (int d = 0; d < 3; d++) begin
         mx[d] = PXI[d]; my[d] = PYI[d]; mdx[d] = 1'b0; mdy[d] = 1'b0; mcnt[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("reset_x", d, ox[d], PXI[d]);
         check("reset_y", d, oy[d], PYI[d]);
         check("reset_dir_x", d, odx[d], 0);
         check("reset_dir_y", d, ody[d], 0);
         check("reset_bounce", d, ob[d], 0);
         check("reset_corner", d, oc[d], 0);
         xprev[d] = PXI[d]; yprev[d] = PYI[d]; stray[d] = 0;
      end
      // Reset is released in the middle of blanking: that blanking must not move anything.
      @(negedge clk);
      for (int d = 0; d < 3; d++) model_frame(d, 1'b1, 1'b0);
      mon_en = 1'b1;
      clr = 1'b0;
      repeat (5) @(negedge clk);

      for (int f = 0; f < 40; f++) begin
         automatic bit pz = (f == 3 || f == 4) || (f >= 8 && f != 12 && f != 30 &&
                                                  $urandom_range(0, 5) == 0);
         automatic bit cl = (f == 12 || f == 30);
         run_frame(pz, cl);
      end
      repeat (6) begin
         @(negedge clk);
         y_px  = 10'($urandom_range(0, 479));
         pause = 1'b0;
      end
      @(posedge clk);
      #2;
      for (int d = 0; d < 3; d++) check("queue_drained", d, exp_q[d].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
